cordic_share_arb: RTL and testbench



---
 rtl/svd_pkg.sv | 9 +
 rtl/rr_pick.sv | 30 +++
 rtl/cordic_share_arb.sv | 116 +++++++++++
 tb/tb_cordic_share_arb.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/svd_pkg.sv
// Shared constants for the SVD datapath: CORDIC latencies and data/phase widths.
package svd_pkg;

  localparam int CORDIC_V_LAT = 19;
  localparam int CORDIC_R_LAT = 20;
  localparam int PHASE_W      = 32;
  localparam int DATA_W       = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, with wrap-around.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    j   = 0;
    win = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && elig[j]) begin
        any    = 1'b1;
        win[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cordic_share_arb.sv
// Round-robin issue of requester operand pairs into one shared pipelined CORDIC,
// with a tag pipeline that routes each returned phase back to its requester.
module cordic_share_arb
  import svd_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = DATA_W,
  parameter int PW   = PHASE_W,
  parameter int LAT  = CORDIC_V_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_x,
  input  logic [NREQ*DW-1:0] req_y,
  output logic [NREQ-1:0]    gnt,
  output logic [DW-1:0]      cor_x,
  output logic [DW-1:0]      cor_y,
  output logic               cor_en,
  input  logic [PW-1:0]      cor_phase,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [PW-1:0]      rsp_phase,
  output logic               busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LAT + 2);

  // Handshake: req[i] is a level held with its operands until the cycle gnt[i]
  // pulses; that gnt cycle is the transfer. req is masked during its own gnt
  // cycle so a requester dropping req right after gnt is never granted twice.
  // rsp_valid[i] is a one-cycle pulse with no back-pressure.

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   ptr_next;
  logic [DW-1:0]   sel_x;
  logic [DW-1:0]   sel_y;
  logic [CW-1:0]   inflight;
  logic [LAT:0]    tag_v;
  logic [IW-1:0]   tag_id [LAT+1];
  logic            retire;

  assign elig = req & ~gnt;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .elig (elig),
    .ptr  (ptr),
    .win  (pick_oh),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        sel_x = req_x[i*DW +: DW];
        sel_y = req_y[i*DW +: DW];
      end
    end
  end

  assign ptr_next = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
  assign cor_en   = (|gnt) | (inflight != '0);
  assign busy     = cor_en;
  assign retire   = cor_en & tag_v[LAT];

  // Stage 0 loads every cycle; it is only ever valid alongside gnt, which keeps
  // cor_en high, so the rest of the pipeline may shift only on cor_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt       <= '0;
      cor_x     <= '0;
      cor_y     <= '0;
      ptr       <= '0;
      inflight  <= '0;
      rsp_valid <= '0;
      rsp_phase <= '0;
      tag_v     <= '0;
      for (int s = 0; s <= LAT; s++) tag_id[s] <= '0;
    end else begin
      gnt       <= pick_oh;
      tag_v[0]  <= pick_any;
      tag_id[0] <= pick_idx;
      if (pick_any) begin
        cor_x <= sel_x;
        cor_y <= sel_y;
        ptr   <= ptr_next;
      end
      if (cor_en) begin
        for (int s = 1; s <= LAT; s++) begin
          tag_v[s]  <= tag_v[s-1];
          tag_id[s] <= tag_id[s-1];
        end
      end
      if (pick_any && !retire) begin
        inflight <= inflight + CW'(1);
      end else if (!pick_any && retire) begin
        inflight <= inflight - CW'(1);
      end
      for (int i = 0; i < NREQ; i++) begin
        rsp_valid[i] <= retire && (tag_id[LAT] == IW'(i));
      end
      if (retire) rsp_phase <= cor_phase;
    end
  end

endmodule

// File: tb/tb_cordic_share_arb.sv
// Directed bench for cordic_share_arb with a gated delay-line CORDIC model returning {x,y}.
module tb_cordic_share_arb;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int PW   = 32;
  localparam int LAT  = 19;
  localparam int QW   = 67;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*DW-1:0] req_x = '0;
  logic [NREQ*DW-1:0] req_y = '0;
  logic [NREQ-1:0]    gnt;
  logic [DW-1:0]      cor_x;
  logic [DW-1:0]      cor_y;
  logic               cor_en;
  logic [PW-1:0]      cor_phase;
  logic [NREQ-1:0]    rsp_valid;
  logic [PW-1:0]      rsp_phase;
  logic               busy;

  logic [DW-1:0] rx [NREQ];
  logic [DW-1:0] ry [NREQ];
  logic [PW-1:0] model_d [LAT];
  logic [QW-1:0] exp_q [$];
  logic [QW-1:0] mon_e;
  int cyc     = 0;
  int n_pass  = 0;
  int n_checks = 0;

  cordic_share_arb #(
    .NREQ (NREQ),
    .DW   (DW),
    .PW   (PW),
    .LAT  (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_x     (req_x),
    .req_y     (req_y),
    .gnt       (gnt),
    .cor_x     (cor_x),
    .cor_y     (cor_y),
    .cor_en    (cor_en),
    .cor_phase (cor_phase),
    .rsp_valid (rsp_valid),
    .rsp_phase (rsp_phase),
    .busy      (busy)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural CORDIC: LAT enabled cycles from operands to phase = {x,y}
  initial for (int k = 0; k < LAT; k++) model_d[k] = '0;
  always @(posedge clk) begin
    if (cor_en) begin
      model_d[0] <= {cor_x, cor_y};
      for (int k = 1; k < LAT; k++) model_d[k] <= model_d[k-1];
    end
  end
  assign cor_phase = model_d[LAT-1];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
  endtask

  // scoreboard: responses in issue order, exact cycle, tag and phase
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0 && int'(exp_q[0][66:35]) < cyc) begin
        mon_e = exp_q.pop_front();
        check("rsp_missing", 64'(cyc), 64'(mon_e[66:35]));
      end
      if (rsp_valid !== '0) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_cycle", 64'(cyc), 64'(mon_e[66:35]));
          check("rsp_tag", 64'(rsp_valid), 64'(4'b0001 << mon_e[34:32]));
          check("rsp_phase", 64'(rsp_phase), 64'(mon_e[31:0]));
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*DW +: DW] = rx[i];
      req_y[i*DW +: DW] = ry[i];
    end
  endtask

  task automatic expect_gnt(input string name, input logic [NREQ-1:0] exp_oh);
    check({name, "_gnt"}, 64'(gnt), 64'(exp_oh));
    for (int i = 0; i < NREQ; i++) begin
      if (exp_oh[i]) begin
        check({name, "_cor_x"}, 64'(cor_x), 64'(rx[i]));
        check({name, "_cor_y"}, 64'(cor_y), 64'(ry[i]));
        exp_q.push_back({32'(cyc + LAT + 1), 3'(i), rx[i], ry[i]});
      end
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_gnt"}, 64'(gnt), 64'(0));
    check({name, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    check({name, "_rsp_phase"}, 64'(rsp_phase), 64'(0));
    check({name, "_cor_x"}, 64'(cor_x), 64'(0));
    check({name, "_cor_y"}, 64'(cor_y), 64'(0));
    check({name, "_cor_en"}, 64'(cor_en), 64'(0));
    check({name, "_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    req = '0;
    exp_q.delete();
    step();
    check_idle(name);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 200) begin
      step();
      n++;
    end
    check({name, "_drain_q"}, 64'(exp_q.size()), 64'(0));
    check({name, "_drain_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    logic [NREQ-1:0] exp_oh;
    int g;
    rx[0] = 16'h1111; ry[0] = 16'hEEEE;
    rx[1] = 16'h2222; ry[1] = 16'hDDDD;
    rx[2] = 16'h0100; ry[2] = 16'h0080;
    rx[3] = 16'h7FFF; ry[3] = 16'h8000;
    apply();

    do_reset("reset");
    step();
    check_idle("post_reset");

    // single request from requester 2
    req = 4'b0100;
    step();
    expect_gnt("single", 4'b0100);
    g = cyc;
    req = '0;
    step();
    expect_gnt("single_nodup", 4'b0000);
    check("single_busy", 64'(busy), 64'(1));
    while (cyc < g + LAT) step();
    check("single_busy_last", 64'(busy), 64'(1));
    step();
    check("single_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    check("single_rsp_phase", 64'(rsp_phase), 64'(32'h0100_0080));
    check("single_busy_fall", 64'(busy), 64'(0));
    drain("single");

    // pointer fairness: ptr=3 after granting 2
    req = 4'b1001;
    step();
    expect_gnt("fair_a", 4'b1000);
    step();
    expect_gnt("fair_b", 4'b0001);
    req = '0;
    step();
    expect_gnt("fair_none_a", 4'b0000);
    step();
    expect_gnt("fair_none_b", 4'b0000);
    req = 4'b1011;
    step();
    expect_gnt("fair_ptr_held", 4'b0010);
    req = '0;
    step();
    expect_gnt("fair_drop", 4'b0000);

    // withdrawal: ptr=2, requester 0 outranks requester 1's one-cycle pulse
    req = 4'b0011;
    step();
    expect_gnt("wd_a", 4'b0001);
    req = 4'b0001;
    step();
    expect_gnt("wd_mask", 4'b0000);
    step();
    expect_gnt("wd_again", 4'b0001);
    req = '0;
    step();
    expect_gnt("wd_end", 4'b0000);
    drain("withdraw");

    // all four continuously from reset
    do_reset("reset2");
    req = 4'b1111;
    for (int j = 0; j < 40; j++) begin
      step();
      exp_oh = NREQ'(1) << (j % NREQ);
      expect_gnt("rr", exp_oh);
      check("rr_cor_en", 64'(cor_en), 64'(1));
      if (j >= LAT) check("rr_inflight", 64'(dut.inflight), 64'(LAT + 1));
      rx[j % NREQ] = rx[j % NREQ] + 16'h0001;
      apply();
    end
    req = '0;
    drain("rr");

    // reset with five operations in flight
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      step();
      exp_oh = NREQ'(1) << (j % NREQ);
      expect_gnt("mid", exp_oh);
    end
    req = '0;
    step();
    expect_gnt("mid_stop", 4'b0000);
    step();
    do_reset("mid_reset");
    for (int j = 0; j < LAT + 5; j++) begin
      step();
      check("mid_quiet", 64'(rsp_valid), 64'(0));
    end
    req = 4'b0010;
    step();
    expect_gnt("after_reset", 4'b0010);
    req = '0;
    drain("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
